// File: rtl/reg_file.sv
// General-purpose operand store: one synchronous write port, two combinational
// read ports with write-first bypass, optional hardwired-zero entry 0.
module reg_file #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ZERO_REG   = 0
) (
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [ADDR_WIDTH-1:0] r2_addr,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write,
  input  logic                  clock,
  output logic [DATA_WIDTH-1:0] r1_out,
  output logic [DATA_WIDTH-1:0] r2_out,
  input  logic                  reset_n
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic write_live;
  logic write_commit;
  logic r1_is_zero;
  logic r2_is_zero;

  // Bypass and commit are both gated by reset so nothing leaks through while held.
  assign write_live   = write && reset_n;
  assign write_commit = write_live && !((ZERO_REG != 0) && (write_addr == '0));
  assign r1_is_zero   = (ZERO_REG != 0) && (r1_addr == '0);
  assign r2_is_zero   = (ZERO_REG != 0) && (r2_addr == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (write_commit) begin
      mem[write_addr] <= write_data;
    end
  end

  always_comb begin
    r1_out = mem[r1_addr];
    if (!reset_n || r1_is_zero) begin
      r1_out = '0;
    end else if (write_live && (r1_addr == write_addr)) begin
      r1_out = write_data;
    end
  end

  always_comb begin
    r2_out = mem[r2_addr];
    if (!reset_n || r2_is_zero) begin
      r2_out = '0;
    end else if (write_live && (r2_addr == write_addr)) begin
      r2_out = write_data;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: 8/8, 16/16 and ZERO_REG=1 instances on a shared
// clock and reset, checked against hand-computed expected values.
module tb_reg_file;

  logic        clock;
  logic        clk_en;
  logic        reset_n;

  logic [7:0]  a1_8, a2_8, wa_8, wd_8, r1_8, r2_8;
  logic        w_8;
  logic [15:0] a1_16, a2_16, wa_16, wd_16, r1_16, r2_16;
  logic        w_16;
  logic [7:0]  a1_z, a2_z, wa_z, wd_z, r1_z, r2_z;
  logic        w_z;

  reg_file #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .ZERO_REG(0)) u_rf8 (
    .r1_addr(a1_8), .r2_addr(a2_8), .write_addr(wa_8), .write_data(wd_8),
    .write(w_8), .clock(clock), .r1_out(r1_8), .r2_out(r2_8), .reset_n(reset_n)
  );

  reg_file #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .ZERO_REG(0)) u_rf16 (
    .r1_addr(a1_16), .r2_addr(a2_16), .write_addr(wa_16), .write_data(wd_16),
    .write(w_16), .clock(clock), .r1_out(r1_16), .r2_out(r2_16), .reset_n(reset_n)
  );

  reg_file #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .ZERO_REG(1)) u_rfz (
    .r1_addr(a1_z), .r2_addr(a2_z), .write_addr(wa_z), .write_data(wd_z),
    .write(w_z), .clock(clock), .r1_out(r1_z), .r2_out(r2_z), .reset_n(reset_n)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    clk_en = 1'b1;
    forever begin
      #5;
      if (clk_en) clock = ~clock;
    end
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int check_cnt = 0;
  int err_cnt   = 0;

  task automatic expect_val(input logic [15:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] actual);
    logic [15:0] exp;
    check_cnt++;
    if (exp_q.size() == 0) begin
      err_cnt++;
      $display("FAIL %s: got %h, no expected value queued", name, actual);
    end else begin
      exp = exp_q.pop_front();
      if (actual !== exp) begin
        err_cnt++;
        $display("FAIL %s: got %h, expected %h", name, actual, exp);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic write8(input logic [7:0] addr, input logic [7:0] data);
    @(negedge clock);
    wa_8 = addr; wd_8 = data; w_8 = 1'b1;
    @(posedge clock);
    #1 w_8 = 1'b0;
  endtask

  task automatic write16(input logic [15:0] addr, input logic [15:0] data);
    @(negedge clock);
    wa_16 = addr; wd_16 = data; w_16 = 1'b1;
    @(posedge clock);
    #1 w_16 = 1'b0;
  endtask

  // ---------------- vector table (8/8 instance) ----------------
  typedef struct {
    logic       we;
    logic [7:0] waddr;
    logic [7:0] wdata;
    logic [7:0] ra1;
    logic [7:0] ra2;
    logic [7:0] exp1;
    logic [7:0] exp2;
  } vec_t;

  vec_t vecs[11];

  initial begin
    reset_n = 1'b0;
    {a1_8, a2_8, wa_8, wd_8, w_8} = '0;
    {a1_16, a2_16, wa_16, wd_16, w_16} = '0;
    {a1_z, a2_z, wa_z, wd_z, w_z} = '0;

    // Each row is checked before its edge, so a live write shows up via bypass.
    vecs[0]  = '{1'b1, 8'd10,  8'h55, 8'd10,  8'd0,   8'h55, 8'h00};
    vecs[1]  = '{1'b1, 8'd11,  8'h05, 8'd10,  8'd11,  8'h55, 8'h05};
    vecs[2]  = '{1'b1, 8'd15,  8'hFF, 8'd11,  8'd15,  8'h05, 8'hFF};
    vecs[3]  = '{1'b0, 8'd15,  8'h00, 8'd10,  8'd15,  8'h55, 8'hFF};
    vecs[4]  = '{1'b1, 8'd20,  8'hA5, 8'd20,  8'd20,  8'hA5, 8'hA5};
    vecs[5]  = '{1'b0, 8'd20,  8'h00, 8'd20,  8'd20,  8'hA5, 8'hA5};
    vecs[6]  = '{1'b0, 8'd0,   8'h00, 8'hFF,  8'd11,  8'h00, 8'h05};
    vecs[7]  = '{1'b1, 8'hFF,  8'h3C, 8'hFF,  8'd10,  8'h3C, 8'h55};
    vecs[8]  = '{1'b0, 8'hFF,  8'h00, 8'hFF,  8'd20,  8'h3C, 8'hA5};
    vecs[9]  = '{1'b1, 8'd10,  8'h66, 8'd11,  8'd15,  8'h05, 8'hFF};
    vecs[10] = '{1'b0, 8'd10,  8'h00, 8'd10,  8'd10,  8'h66, 8'h66};

    // Reset state
    #12;
    a1_8 = 8'd10; a2_8 = 8'hFF;
    #1;
    expect_val(16'h0000); check("reset_r1", {8'h00, r1_8});
    expect_val(16'h0000); check("reset_r2", {8'h00, r2_8});
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      @(negedge clock);
      w_8 = vecs[i].we; wa_8 = vecs[i].waddr; wd_8 = vecs[i].wdata;
      a1_8 = vecs[i].ra1; a2_8 = vecs[i].ra2;
      #1;
      expect_val({8'h00, vecs[i].exp1}); check($sformatf("vec%0d_r1", i), {8'h00, r1_8});
      expect_val({8'h00, vecs[i].exp2}); check($sformatf("vec%0d_r2", i), {8'h00, r2_8});
    end
    @(negedge clock);
    w_8 = 1'b0;

    // 16/16 boundary addresses on consecutive edges
    write16(16'hF00D, 16'hABCD);
    write16(16'h1111, 16'h1234);
    write16(16'hFFFF, 16'h5678);
    a1_16 = 16'hF00D; a2_16 = 16'h1111;
    #1;
    expect_val(16'hABCD); check("w16_f00d", r1_16);
    expect_val(16'h1234); check("w16_1111", r2_16);
    a1_16 = 16'hFFFF; a2_16 = 16'h0000;
    #1;
    expect_val(16'h5678); check("w16_ffff", r1_16);
    expect_val(16'h0000); check("w16_zero_unwritten", r2_16);
    a1_8 = 8'd10; a2_8 = 8'hFF;
    #1;
    expect_val(16'h0066); check("rf8_untouched_10", {8'h00, r1_8});
    expect_val(16'h003C); check("rf8_untouched_ff", {8'h00, r2_8});

    // ZERO_REG: address 0 stays zero, bypass included
    @(negedge clock);
    wa_z = 8'd0; wd_z = 8'h77; w_z = 1'b1; a1_z = 8'd0; a2_z = 8'd0;
    #1;
    expect_val(16'h0000); check("zr_bypass_r1", {8'h00, r1_z});
    expect_val(16'h0000); check("zr_bypass_r2", {8'h00, r2_z});
    @(posedge clock);
    #1 w_z = 1'b0;
    #1;
    expect_val(16'h0000); check("zr_after_write", {8'h00, r1_z});
    @(negedge clock);
    wa_z = 8'd1; wd_z = 8'h77; w_z = 1'b1; a2_z = 8'd1;
    #1;
    expect_val(16'h0077); check("zr_a1_bypass", {8'h00, r2_z});
    @(posedge clock);
    #1 w_z = 1'b0;
    #1;
    expect_val(16'h0077); check("zr_a1_stored", {8'h00, r2_z});
    expect_val(16'h0000); check("zr_a0_still0", {8'h00, r1_z});

    // Mid-run reset with the clock stopped
    @(negedge clock);
    clk_en = 1'b0;
    #2;
    a1_8 = 8'd10; a2_8 = 8'hFF; a1_16 = 16'hF00D; a2_z = 8'd1;
    reset_n = 1'b0;
    #1;
    expect_val(16'h0000); check("midrst_r1_10", {8'h00, r1_8});
    expect_val(16'h0000); check("midrst_r2_ff", {8'h00, r2_8});
    expect_val(16'h0000); check("midrst_rf16", r1_16);
    expect_val(16'h0000); check("midrst_rfz", {8'h00, r2_z});
    wa_8 = 8'd10; wd_8 = 8'h99; w_8 = 1'b1;
    #1;
    expect_val(16'h0000); check("midrst_no_bypass", {8'h00, r1_8});
    w_8 = 1'b0;
    #1 reset_n = 1'b1;
    #1;
    expect_val(16'h0000); check("after_rst_cleared", {8'h00, r1_8});
    clk_en = 1'b1;

    // First edge after deassertion accepts a write
    write8(8'd10, 8'h42);
    #1;
    expect_val(16'h0042); check("first_write_after_rst", {8'h00, r1_8});
    repeat (2) @(posedge clock);
    #1;
    expect_val(16'h0042); check("first_write_holds", {8'h00, r1_8});

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: run did not complete, expected finish before 20000");
    $fatal(1);
  end

endmodule
